// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// The clear FSM state type and the address-width helper live here.
package regfile_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;

    function automatic int rf_aw(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port of the register file: range/zero filtering
// plus same-cycle write-to-read bypass, port 1 taking priority over port 0.
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic             ready,
    input  logic [AW-1:0]    raddr,
    input  logic [WIDTH-1:0] stored,
    input  logic             we0_eff,
    input  logic [AW-1:0]    waddr0,
    input  logic [WIDTH-1:0] wdata0,
    input  logic             we1_eff,
    input  logic [AW-1:0]    waddr1,
    input  logic [WIDTH-1:0] wdata1,
    output logic [WIDTH-1:0] rdata
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    logic raddr_ok;

    // A power-of-two depth leaves no unused address codes to reject.
    if (DEPTH == (1 << AW)) begin : g_full
        assign raddr_ok = 1'b1;
    end else begin : g_part
        assign raddr_ok = (raddr <= LAST_ADDR);
    end

    always_comb begin
        rdata = '0;
        if (!ready || !raddr_ok) begin
            rdata = '0;
        end else if ((ZERO_REG != 0) && (raddr == '0)) begin
            rdata = '0;
        end else if (we1_eff && (waddr1 == raddr)) begin
            rdata = wdata1;
        end else if (we0_eff && (waddr0 == raddr)) begin
            rdata = wdata0;
        end else begin
            rdata = stored;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NRD async read ports with write bypass, two write
// ports (port 1 wins on collision) and a one-entry-per-cycle clear engine.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int WIDTH    = 32,
    parameter  int DEPTH    = 32,
    parameter  int NRD      = 2,
    parameter  int ZERO_REG = 1,
    localparam int AW       = rf_aw(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_req,
    output logic                 ready,
    input  logic                 we0,
    input  logic [AW-1:0]        waddr0,
    input  logic [WIDTH-1:0]     wdata0,
    input  logic                 we1,
    input  logic [AW-1:0]        waddr1,
    input  logic [WIDTH-1:0]     wdata1,
    input  logic [NRD*AW-1:0]    raddr,
    output logic [NRD*WIDTH-1:0] rdata
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    rf_state_e        state;
    rf_state_e        state_next;
    logic [AW-1:0]    clr_cnt;
    logic [AW-1:0]    clr_cnt_next;
    logic             waddr0_ok;
    logic             waddr1_ok;
    logic             we0_eff;
    logic             we1_eff;

    // Async multi-port reads keep this in distributed logic rather than block RAM.
    logic [WIDTH-1:0] mem [DEPTH];

    assign ready = (state == RF_READY);

    if (DEPTH == (1 << AW)) begin : g_wfull
        assign waddr0_ok = 1'b1;
        assign waddr1_ok = 1'b1;
    end else begin : g_wpart
        assign waddr0_ok = (waddr0 <= LAST_ADDR);
        assign waddr1_ok = (waddr1 <= LAST_ADDR);
    end

    assign we0_eff = we0 && ready && waddr0_ok && !((ZERO_REG != 0) && (waddr0 == '0));
    assign we1_eff = we1 && ready && waddr1_ok && !((ZERO_REG != 0) && (waddr1 == '0));

    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        case (state)
            RF_CLEAR: begin
                clr_cnt_next = clr_cnt + 1'b1;
                if (clr_cnt == LAST_ADDR) begin
                    state_next   = RF_READY;
                    clr_cnt_next = '0;
                end
            end
            RF_READY: begin
                if (clr_req) begin
                    state_next   = RF_CLEAR;
                    clr_cnt_next = '0;
                end
            end
            default: begin
                state_next   = RF_CLEAR;
                clr_cnt_next = '0;
            end
        endcase
    end

    // Storage is deliberately not reset; the clear sequence zeroes it instead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RF_CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_next;
            clr_cnt <= clr_cnt_next;
            if (state == RF_CLEAR) begin
                mem[clr_cnt] <= '0;
            end else begin
                if (we0_eff) begin
                    mem[waddr0] <= wdata0;
                end
                if (we1_eff) begin
                    mem[waddr1] <= wdata1;
                end
            end
        end
    end

    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic [AW-1:0]    ra;
        logic [WIDTH-1:0] stored;

        assign ra     = raddr[gi*AW +: AW];
        assign stored = mem[ra];

        regfile_rdport #(
            .WIDTH   (WIDTH),
            .DEPTH   (DEPTH),
            .AW      (AW),
            .ZERO_REG(ZERO_REG)
        ) u_rdport (
            .ready  (ready),
            .raddr  (ra),
            .stored (stored),
            .we0_eff(we0_eff),
            .waddr0 (waddr0),
            .wdata0 (wdata0),
            .we1_eff(we1_eff),
            .waddr1 (waddr1),
            .wdata1 (wdata1),
            .rdata  (rdata[gi*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: three instances (zero-reg, plain entry 0,
// and a 24-deep 3-read-port variant) share the write/clear stimulus.
module tb_regfile_mp;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst_n_c, clr_req;
    logic        we0, we1;
    logic [4:0]  waddr0, waddr1;
    logic [31:0] wdata0, wdata1;
    logic [9:0]  raddr_a, raddr_b;
    logic [14:0] raddr_c;
    logic        ready_a, ready_b, ready_c;
    logic [63:0] rdata_a, rdata_b;
    logic [95:0] rdata_c;

    regfile_mp #(.WIDTH(32), .DEPTH(32), .NRD(2), .ZERO_REG(1)) u_a (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .ready(ready_a),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr_a), .rdata(rdata_a)
    );

    regfile_mp #(.WIDTH(32), .DEPTH(32), .NRD(2), .ZERO_REG(0)) u_b (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .ready(ready_b),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr_b), .rdata(rdata_b)
    );

    regfile_mp #(.WIDTH(32), .DEPTH(24), .NRD(3), .ZERO_REG(1)) u_c (
        .clk(clk), .rst_n(rst_n_c), .clr_req(clr_req), .ready(ready_c),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr_c), .rdata(rdata_c)
    );

    typedef struct {
        string       tag;
        int          dut;
        int          port;
        logic [31:0] exp;
    } sb_t;

    sb_t         sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] mdl [3][32];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    function automatic int nrd(input int d);
        return (d == 2) ? 3 : 2;
    endfunction

    function automatic int depth_of(input int d);
        return (d == 2) ? 24 : 32;
    endfunction

    function automatic bit zr(input int d);
        return d != 1;
    endfunction

    function automatic logic [4:0] get_ra(input int d, input int p);
        case (d)
            0:       return raddr_a[p*5 +: 5];
            1:       return raddr_b[p*5 +: 5];
            default: return raddr_c[p*5 +: 5];
        endcase
    endfunction

    function automatic logic [31:0] get_rd(input int d, input int p);
        case (d)
            0:       return rdata_a[p*32 +: 32];
            1:       return rdata_b[p*32 +: 32];
            default: return rdata_c[p*32 +: 32];
        endcase
    endfunction

    function automatic bit eff(input int d, input logic we, input logic [4:0] a);
        return we && (int'(a) < depth_of(d)) && !(zr(d) && a == 5'd0);
    endfunction

    // Expected read value of a ready instance given the currently driven writes.
    function automatic logic [31:0] mdl_rd(input int d, input logic [4:0] a);
        if (int'(a) >= depth_of(d) || (zr(d) && a == 5'd0)) return 32'h0;
        if (eff(d, we1, waddr1) && waddr1 == a) return wdata1;
        if (eff(d, we0, waddr0) && waddr0 == a) return wdata0;
        return mdl[d][a];
    endfunction

    task automatic expect_rd(input string tag, input int d, input int p, input logic [31:0] e);
        sb_t item;
        item.tag  = tag;
        item.dut  = d;
        item.port = p;
        item.exp  = e;
        sb.push_back(item);
    endtask

    task automatic expect_model(input string tag);
        for (int d = 0; d < 3; d++)
            for (int p = 0; p < nrd(d); p++)
                expect_rd($sformatf("%s_d%0d_p%0d_a%0d", tag, d, p, get_ra(d, p)),
                          d, p, mdl_rd(d, get_ra(d, p)));
    endtask

    task automatic set_all_ra(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
        raddr_a = {a1, a0};
        raddr_b = {a1, a0};
        raddr_c = {a2, a1, a0};
    endtask

    task automatic zero_model(input int d);
        for (int a = 0; a < 32; a++) mdl[d][a] = 32'h0;
    endtask

    // Compare queued expectations mid-cycle, then commit writes to the model.
    task automatic step();
        bit  rdy [3];
        sb_t e;
        @(negedge clk);
        rdy[0] = ready_a;
        rdy[1] = ready_b;
        rdy[2] = ready_c;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, get_rd(e.dut, e.port), e.exp);
        end
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            if (rdy[d]) begin
                if (eff(d, we0, waddr0)) mdl[d][waddr0] = wdata0;
                if (eff(d, we1, waddr1)) mdl[d][waddr1] = wdata1;
            end
        end
        #1;
    endtask

    task automatic rand_cycle(input string tag);
        we0    = 1'($urandom_range(0, 1));
        we1    = 1'($urandom_range(0, 1));
        waddr0 = 5'($urandom_range(0, 31));
        waddr1 = ($urandom_range(0, 3) == 0) ? waddr0 : 5'($urandom_range(0, 31));
        wdata0 = $urandom;
        wdata1 = $urandom;
        set_all_ra(($urandom_range(0, 2) == 0) ? waddr0 : 5'($urandom_range(0, 31)),
                   ($urandom_range(0, 2) == 0) ? waddr1 : 5'($urandom_range(0, 31)),
                   5'($urandom_range(0, 31)));
        expect_model(tag);
        step();
    endtask

    // Counts negedges with ready_a low (and when ready_c rose) during a clear.
    task automatic run_clear(input bit noise, output int na, output int nc);
        bit seen = 1'b0;
        na = 0;
        nc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ready_c && !seen) begin
                seen = 1'b1;
                nc   = na;
            end
            if (ready_a) break;
            if (noise) begin
                if (na == 1) check("t5_clear_rd_a", rdata_a[31:0], 32'h0);
                if (na == 1) check("t5_clear_rd_b", rdata_b[63:32], 32'h0);
                if (na == 2) begin
                    we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h3333_3333;
                    we1 = 1'b1; waddr1 = 5'd4; wdata1 = 32'h4444_4444;
                end
                if (na == 4) begin we0 = 1'b0; we1 = 1'b0; end
                if (na == 5) clr_req = 1'b1;
                if (na == 6) clr_req = 1'b0;
            end
            na++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int na, nc, n;
        bit pulsed;

        rst_n = 1'b0; rst_n_c = 1'b0; clr_req = 1'b0;
        we0 = 1'b0; we1 = 1'b0; waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
        set_all_ra(5'd0, 5'd0, 5'd0);
        for (int d = 0; d < 3; d++) zero_model(d);

        // Reset and the initial clear sequence
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready_a", 32'(ready_a), 32'h0);
        check("rst_ready_c", 32'(ready_c), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1; rst_n_c = 1'b1;
        run_clear(1'b0, na, nc);
        check("rst_clear_len_a", 32'(na), 32'd32);
        check("rst_clear_len_c", 32'(nc), 32'd24);
        @(posedge clk); #1;
        for (int a = 0; a < 32; a++) begin
            set_all_ra(5'(a), 5'(31 - a), 5'(a));
            expect_model("rst_zero");
            step();
        end

        // Write-port 0 bypass then array read
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEAD_BEEF;
        set_all_ra(5'd5, 5'd5, 5'd5);
        expect_rd("t2_bypass", 0, 0, 32'hDEAD_BEEF);
        expect_model("t2_byp");
        step();
        we0 = 1'b0;
        expect_rd("t2_array", 0, 0, 32'hDEAD_BEEF);
        expect_model("t2_arr");
        step();

        // Same-address collision: port 1 wins
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22;
        set_all_ra(5'd7, 5'd7, 5'd7);
        expect_rd("t3_bypass", 0, 1, 32'h22);
        step();
        we0 = 1'b0; we1 = 1'b0;
        expect_rd("t3_array", 0, 1, 32'h22);
        expect_rd("t3_array_b", 1, 0, 32'h22);
        step();

        // Entry 0: hardwired in A/C, ordinary storage in B
        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFF_FFFF;
        set_all_ra(5'd0, 5'd0, 5'd0);
        expect_rd("t4_zr1_byp", 0, 0, 32'h0);
        expect_rd("t4_zr0_byp", 1, 0, 32'hFFFF_FFFF);
        step();
        we0 = 1'b0;
        expect_rd("t4_zr1_arr", 0, 0, 32'h0);
        expect_rd("t4_zr0_arr", 1, 0, 32'hFFFF_FFFF);
        expect_rd("t4_zr1_arr_c", 2, 2, 32'h0);
        step();

        // Different addresses on both ports are both stored
        we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'hA9;
        we1 = 1'b1; waddr1 = 5'd10; wdata1 = 32'hAA;
        set_all_ra(5'd1, 5'd2, 5'd3);
        step();
        we0 = 1'b0; we1 = 1'b0;
        set_all_ra(5'd9, 5'd10, 5'd9);
        expect_rd("dual_p0", 0, 0, 32'hA9);
        expect_rd("dual_p1", 0, 1, 32'hAA);
        step();

        for (int i = 0; i < 60; i++) rand_cycle("rnd1");
        we0 = 1'b0; we1 = 1'b0;

        // Requested clear with writes and a second request during it
        set_all_ra(5'd5, 5'd7, 5'd5);
        clr_req = 1'b1;
        @(posedge clk); #1;
        clr_req = 1'b0;
        run_clear(1'b1, na, nc);
        check("t5_clear_len_a", 32'(na), 32'd32);
        check("t5_clear_len_c", 32'(nc), 32'd24);
        we0 = 1'b0; we1 = 1'b0; clr_req = 1'b0;
        for (int d = 0; d < 3; d++) zero_model(d);
        @(posedge clk); #1;
        for (int a = 0; a < 32; a++) begin
            set_all_ra(5'(a), 5'(31 - a), 5'((a + 3) % 32));
            expect_model("t5_zero");
            step();
        end

        // Out-of-range address on the 24-deep instance
        we0 = 1'b1; waddr0 = 5'd30; wdata0 = 32'h3030_3030;
        set_all_ra(5'd30, 5'd6, 5'd30);
        expect_rd("t6_oob_byp", 2, 2, 32'h0);
        expect_rd("t6_oob_byp_a", 0, 0, 32'h3030_3030);
        step();
        we0 = 1'b0;
        expect_rd("t6_oob_arr", 2, 0, 32'h0);
        expect_rd("t6_alias6", 2, 1, 32'h0);
        step();

        for (int i = 0; i < 30; i++) rand_cycle("rnd2");
        we0 = 1'b0; we1 = 1'b0;

        // Reset the 24-deep instance, then again at clear cycle 10
        @(negedge clk);
        rst_n_c = 1'b0; #2; rst_n_c = 1'b1;
        n = 0;
        pulsed = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ready_c) break;
            if (n == 5) check("t6_clear_rd_c", rdata_c[95:64], 32'h0);
            if (n == 10 && !pulsed) begin
                rst_n_c = 1'b0; #2; rst_n_c = 1'b1;
                pulsed = 1'b1;
                n = 0;
            end else begin
                n++;
            end
        end
        check("t6_restart_len_c", 32'(n + 1), 32'd24);
        zero_model(2);
        @(posedge clk); #1;
        for (int a = 0; a < 32; a++) begin
            set_all_ra(5'(a), 5'(31 - a), 5'((a + 7) % 32));
            expect_model("t6_zero");
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
